// File: rtl/cla6_mp_add_seq_pkg.sv
// Shared definitions for the chunked multi-precision add/subtract sequencer.
package cla6_mp_add_seq_pkg;

  // Width of one adder chunk.
  localparam int unsigned CLA_CHUNK = 6;

  // Sequencer states; encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the chunk index: max(1, clog2(words)).
  function automatic int unsigned k_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cla6_mp_add_seq_cla6.sv
// CLA6: purely combinational 6-bit carry-lookahead adder.
module CLA6
  import cla6_mp_add_seq_pkg::*;
(
  input  logic [CLA_CHUNK-1:0] A,
  input  logic [CLA_CHUNK-1:0] B,
  input  logic                 Cin,
  output logic [CLA_CHUNK-1:0] So,
  output logic                 Cout
);

  logic [CLA_CHUNK-1:0] g;
  logic [CLA_CHUNK-1:0] p;
  logic [CLA_CHUNK:0]   c;
  logic                 acc;
  logic                 pp;

  // Each carry is expanded as a flat generate/propagate sum-of-products
  // over all lower positions, so no carry depends on another carry.
  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c    = '0;
    acc  = 1'b0;
    pp   = 1'b1;
    c[0] = Cin;
    for (int unsigned i = 0; i < CLA_CHUNK; i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int unsigned j = 0; j <= i; j++) begin
        acc = acc | (pp & g[i-j]);
        pp  = pp & p[i-j];
      end
      c[i+1] = acc | (pp & Cin);
    end
  end

  assign So   = p ^ c[CLA_CHUNK-1:0];
  assign Cout = c[CLA_CHUNK];

endmodule

// File: rtl/cla6_mp_add_seq.sv
// cla6_mp_add_seq: feeds a 6*WORDS-bit add/subtract through one shared CLA6,
// one chunk per clock, LSB first, with a start/done handshake.
module cla6_mp_add_seq
  import cla6_mp_add_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       sub,
  input  logic                       cin,
  input  logic [CLA_CHUNK*WORDS-1:0] a_in,
  input  logic [CLA_CHUNK*WORDS-1:0] b_in,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  output logic [CLA_CHUNK*WORDS-1:0] sum,
  output logic                       cout,
  output logic                       ovf
);

  localparam int unsigned W  = CLA_CHUNK * WORDS;
  localparam int unsigned KW = k_width(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic [CLA_CHUNK-1:0] cla_a;
  logic [CLA_CHUNK-1:0] cla_b;
  logic [CLA_CHUNK-1:0] cla_so;
  logic                 cla_co;

  assign cla_a = a_q[k_q*CLA_CHUNK +: CLA_CHUNK];
  assign cla_b = b_q[k_q*CLA_CHUNK +: CLA_CHUNK];

  CLA6 u_cla6 (
    .A    (cla_a),
    .B    (cla_b),
    .Cin  (carry_q),
    .So   (cla_so),
    .Cout (cla_co)
  );

  // Next-state logic: operand capture, per-chunk writeback, final flags.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = sub ? ~b_in : b_in;
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[k_q*CLA_CHUNK +: CLA_CHUNK] = cla_so;
        carry_d = cla_co;
        if (k_q == K_LAST) begin
          // k holds on the last chunk instead of wrapping.
          cout_d  = cla_co;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (cla_so[CLA_CHUNK-1] != a_q[W-1]);
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule
